// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: request/grant/data bundle between requesters and the shared memory arbiter
interface mem_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 64
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;
  modport master (output req, we, addr, wdata, input gnt, done, rdata, busy);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata, busy);
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin arbiter owning a 2**AW x DW single-port memory; optional stats via MEM_ARB_STATS_EN
module mem_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_rr_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_grants,
  output logic [31:0]       stat_stall
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [2**AW];
  function automatic logic [NREQ-1:0] oh(input logic [IW-1:0] i);
    return NREQ'(1) << i;
  endfunction
  // round-robin pick: scan downward so the nearest requester after last wins
  always_comb begin
    win  = last;
    cand = last;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (bus.req[cand]) win = cand;
    end
  end
  // IDLE -> ACCESS -> RESP sequencer with registered grant/done/rdata/busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IW'(NREQ - 1);
      idx       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          state    <= ACCESS;
          last     <= win;
          idx      <= win;
          we_q     <= bus.we[win];
          addr_q   <= bus.addr[win*AW +: AW];
          wdata_q  <= bus.wdata[win*DW +: DW];
          bus.gnt  <= oh(win);
          bus.busy <= 1'b1;
        end
        ACCESS: begin
          state    <= RESP;
          bus.gnt  <= '0;
          bus.done <= oh(idx);
          if (!we_q) bus.rdata <= mem[addr_q];
        end
        RESP: begin
          state    <= IDLE;
          bus.done <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  // memory write at the closing edge of ACCESS; storage itself is never reset
  always_ff @(posedge clk)
    if (rst_n && state == ACCESS && we_q) mem[addr_q] <= wdata_q;
`ifdef MEM_ARB_STATS_EN
  // grant count and cycles where a non-granted requester waits while busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      if (state == IDLE && |bus.req) stat_grants <= stat_grants + 32'd1;
      if (bus.busy && |(bus.req & ~oh(idx))) stat_stall <= stat_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed checks of reset, access timing, round-robin order and boundaries
module tb_mem_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] rd;
  int gi[6];
  int gc[6];
  int n;
  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
  always #5 clk = ~clk;
  mem_rr_arbiter_if #(.NREQ(4), .AW(8), .DW(64)) bus ();
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_stall;
`endif
  mem_rr_arbiter #(.NREQ(4), .AW(8), .DW(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall(stat_stall)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one access from idle: grant on the first edge, done on the second, idle after the third
  task automatic do_access(input int i, input logic w, input logic [7:0] a, input logic [63:0] d,
                           output logic [63:0] r);
    bus.req[i] = 1'b1;
    bus.we[i] = w;
    bus.addr[i*8 +: 8] = a;
    bus.wdata[i*64 +: 64] = d;
    @(posedge clk); #1;
    chk("acc_gnt", 64'(bus.gnt), 64'(4'b0001 << i));
    bus.req[i] = 1'b0;
    @(posedge clk); #1;
    chk("acc_done", 64'(bus.done), 64'(4'b0001 << i));
    r = bus.rdata;
    @(posedge clk); #1;
    chk("acc_idle", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    do_access(0, 1'b1, 8'h05, 64'h5555_5555_5555_5555, rd);
    do_access(0, 1'b0, 8'h05, 64'h0, rd);
    chk("pre_rd5", rd, 64'h5555_5555_5555_5555);
    bus.req[0] = 1'b1;
    bus.we[0] = 1'b1;
    bus.addr[7:0] = 8'h05;
    bus.wdata[63:0] = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    chk("mid_gnt", 64'(bus.gnt), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(bus.gnt), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_rdata", bus.rdata, 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    bus.req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_access(0, 1'b0, 8'h05, 64'h0, rd);
    chk("abort_rd5", rd, 64'h5555_5555_5555_5555);
    do_access(0, 1'b1, 8'h10, 64'h0123_4567_89AB_CDEF, rd);
    chk("wr_hold_rdata", rd, 64'h5555_5555_5555_5555);
    do_access(0, 1'b0, 8'h10, 64'h0, rd);
    chk("rd_10", rd, 64'h0123_4567_89AB_CDEF);
    do_access(1, 1'b1, 8'h00, 64'h1, rd);
    do_access(2, 1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, rd);
    do_access(3, 1'b0, 8'h00, 64'h0, rd);
    chk("rd_00", rd, 64'h1);
    do_access(0, 1'b0, 8'hFF, 64'h0, rd);
    chk("rd_ff", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.we = '0;
    bus.req[1] = 1'b1;
    bus.addr[15:8] = 8'h10;
    bus.addr[23:16] = 8'hFF;
    @(posedge clk); #1;
    chk("late_gnt1", 64'(bus.gnt), 64'b0010);
    bus.req[1] = 1'b0;
    bus.req[2] = 1'b1;
    @(posedge clk); #1;
    chk("late_done1", 64'(bus.done), 64'b0010);
    chk("late_rd1", bus.rdata, 64'h0123_4567_89AB_CDEF);
    chk("late_nognt_resp", 64'(bus.gnt), 64'd0);
    @(posedge clk); #1;
    chk("late_nognt_idle", 64'(bus.gnt), 64'd0);
    @(posedge clk); #1;
    chk("late_gnt2", 64'(bus.gnt), 64'b0100);
    bus.req[2] = 1'b0;
    @(posedge clk); #1;
    chk("late_rd2", bus.rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.addr = {4{8'h10}};
    bus.req = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      @(posedge clk); #1;
      if (|bus.gnt) begin
        gi[n] = $clog2(bus.gnt);
        gc[n] = c;
        n++;
      end
    end
    chk("rr_count", 64'(n), 64'd6);
    for (int k = 0; k < n; k++) begin
      chk("rr_order", 64'(gi[k]), 64'(rr_exp[k]));
      if (k > 0) chk("rr_gap", 64'(gc[k] - gc[k-1]), 64'd3);
    end
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_idle", 64'(bus.busy), 64'd0);
`ifdef MEM_ARB_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("st_rst_grants", 64'(stat_grants), 64'd0);
    chk("st_rst_stall", 64'(stat_stall), 64'd0);
    bus.req = 4'b0011;
    repeat (12) @(posedge clk);
    #1;
    chk("st_grants", 64'(stat_grants), 64'd4);
    chk("st_stall", 64'(stat_stall), 64'd8);
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
